mmio_console: RTL
=================

# mmio_console

Memory-mapped simulation I/O and statistics block. It sits on the data-memory write port beside `datamemory` and decodes stores to the console addresses: character output, integer output and halt. Accepted output items are buffered in a small FIFO that a downstream consumer (bench printer or UART shim) drains. The block also keeps the cycle counter and the branch-prediction statistics counters, and freezes them at halt.

## Interface
- `FIFO_DEPTH`, 8: output FIFO entries; power of two, ≥2
- `ADDR_CHAR`, 32'h0: byte-output store address
- `ADDR_INT`, 32'h4: integer-output store address
- `ADDR_HALT`, 32'h8: halt-request store address
- `clk`  in  1  core clock
- `reset_x`  in  1  asynchronous, active-low reset
- `dmem_we`  in  1  data-memory write enable
- `dmem_addr`  in  32  data-memory address
- `dmem_wdata`  in  32  data-memory write data
- `prmiss`  in  1  branch-prediction miss pulse from pipe
- `prsuccess`  in  1  branch-prediction success pulse from pipe
- `combranch`  in  1  committed-branch pulse from pipe
- `mmio_hit`  out  1  combinational; `dmem_addr` matches any console address
- `out_valid`  out  1  FIFO head valid
- `out_kind`  out  1  0 = char, 1 = integer
- `out_data`  out  32  char in [7:0] with [31:8] = 0, or full integer
- `out_ready`  in  1  consumer accepts head
- `overflow`  out  1  sticky; an output store was dropped
- `halt`  out  1  block in HALTED
- `cycle_cnt`  out  32  cycles since reset release
- `prnum_cnt`, `prsu_cnt`, `prmi_cnt`, `prcom_cnt`  out  32 each  prediction statistics

## Operation
- Store decode happens only in RUN, qualified by `dmem_we`.
  - `ADDR_CHAR`: push {kind 0, `dmem_wdata[7:0]` zero-extended}.
  - `ADDR_INT`: push {kind 1, `dmem_wdata`}.
  - `ADDR_HALT`: go to DRAIN; data is ignored.
- Push rule: the push is accepted if the FIFO is not full, or if it is full and a pop happens in the same cycle. Otherwise the item is dropped and `overflow` sets; it clears only on reset.
- Pop: `out_valid && out_ready`. The head is stable while `out_valid && !out_ready`.
- FSM states:
  - RUN → DRAIN on a halt store.
  - DRAIN → HALTED on the first cycle in DRAIN in which the FIFO is empty at the clock edge.
  - HALTED holds until reset.
  - In DRAIN and HALTED, all console stores are ignored and `overflow` is not touched.
- Counters:
  - `cycle_cnt` increments every cycle in RUN and DRAIN.
  - `prmi_cnt` += `prmiss`; `prsu_cnt` += `prsuccess`; `prnum_cnt` += `prmiss` + `prsuccess` (+2 when both pulse in one cycle); `prcom_cnt` += `combranch`.
  - All counters are frozen in HALTED and wrap modulo 2^32.
- `mmio_hit` does not depend on state. The integration uses it to suppress the backing-memory write.

## Timing
- Reset (async assert, sync release): FSM = RUN; FIFO empty; every counter = 0; `out_valid` = 0, `out_kind` = 0, `out_data` = 0, `overflow` = 0, `halt` = 0.
- A store accepted at edge N appears at the FIFO head with `out_valid` = 1 after edge N, if the FIFO was empty. There is no combinational path from `dmem_*` to `out_*`.
- A halt store at edge N with the FIFO empty gives DRAIN after N, then HALTED and `halt` = 1 after N+1.
- The cycle in which HALTED is entered is the last cycle that is counted.
- Reset mid-operation discards FIFO contents and all counters immediately.
- FIFO pointers carry one extra wrap bit, which distinguishes full from empty.

## Configuration
- `MMIO_PRSTAT_EN` defined: the four prediction counters are implemented as described.
- `MMIO_PRSTAT_EN` undefined:
  - The prediction counters are not instantiated and their outputs are tied to 0.
  - `prmiss`, `prsuccess` and `combranch` are unused.
  - `cycle_cnt`, the FIFO and the halt logic are unchanged.

## Structure
- Shared package/header holds: the console address defaults, FSM state encodings (RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2), the item kind codes, and the FIFO item width (33).
- One sub-module: `mmio_fifo`, a synchronous FIFO parameterized by depth and width, with push/pop/full/empty and same-cycle push+pop when full.
- `mmio_console` holds the decode, the FSM and the counters.

## Test plan
- Store 0x41 to 0x0 with `out_ready` = 1 → one cycle later `out_valid` = 1, `out_kind` = 0, `out_data` = 0x41, popped the same cycle.
- Store 0xFFFFFFFF to 0x4 with `out_ready` = 0 for 5 cycles → head holds kind 1, data 0xFFFFFFFF throughout; it is consumed when ready rises.
- Nine char stores with `out_ready` = 0, depth 8 → first 8 are retained in order, `overflow` = 1; then drain and see exactly 8 items.
- Two chars queued, then a halt store, `out_ready` = 1 → `halt` stays 0 until both items are popped, then rises; `cycle_cnt` is constant afterwards; a later store to 0x0 is ignored.
- `prmiss` = `prsuccess` = 1 for 3 cycles, `combranch` = 1 for 2 cycles → `prnum_cnt` = 6, `prmi_cnt` = 3, `prsu_cnt` = 3, `prcom_cnt` = 2 (all 0 when `MMIO_PRSTAT_EN` is undefined).
- Assert `reset_x` low mid-drain with 3 items queued → `out_valid`, `halt` and all counters are 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mmio_console_pkg.sv
// Shared definitions for the memory-mapped console: address defaults, FSM states,
// item kind codes and FIFO item width.
package mmio_console_pkg;

  localparam logic [31:0] AddrCharDef = 32'h0000_0000;
  localparam logic [31:0] AddrIntDef  = 32'h0000_0004;
  localparam logic [31:0] AddrHaltDef = 32'h0000_0008;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StDrain  = 2'd1,
    StHalted = 2'd2
  } state_e;

  localparam logic KindChar = 1'b0;
  localparam logic KindInt  = 1'b1;

  // {kind, data[31:0]}
  localparam int unsigned ItemW = 33;

endpackage

// File: rtl/mmio_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a push into a full FIFO is accepted
// when a pop happens in the same cycle.
module mmio_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 33
) (
  input  logic             clk,
  input  logic             reset_x,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AW:0]      wptr_q, rptr_q;
  logic             do_push, do_pop;

  always_comb begin
    empty   = (wptr_q == rptr_q);
    full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    rdata   = mem_q[rptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/mmio_console.sv
// Console store decode, run/drain/halt FSM, cycle and branch-prediction counters.
// Prediction counters exist only when MMIO_PRSTAT_EN is defined.
module mmio_console
  import mmio_console_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] ADDR_CHAR  = AddrCharDef,
  parameter logic [31:0] ADDR_INT   = AddrIntDef,
  parameter logic [31:0] ADDR_HALT  = AddrHaltDef
) (
  input  logic        clk,
  input  logic        reset_x,
  input  logic        dmem_we,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic        prmiss,
  input  logic        prsuccess,
  input  logic        combranch,
  output logic        mmio_hit,
  output logic        out_valid,
  output logic        out_kind,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        overflow,
  output logic        halt,
  output logic [31:0] cycle_cnt,
  output logic [31:0] prnum_cnt,
  output logic [31:0] prsu_cnt,
  output logic [31:0] prmi_cnt,
  output logic [31:0] prcom_cnt
);

  state_e           state_q, state_d;
  logic             overflow_q;
  logic [31:0]      cycle_q;
  logic             push_req, pop, fifo_full, fifo_empty, counting;
  logic [ItemW-1:0] push_item, head_item;

  always_comb begin
    mmio_hit  = (dmem_addr == ADDR_CHAR) || (dmem_addr == ADDR_INT) ||
                (dmem_addr == ADDR_HALT);
    push_req  = (state_q == StRun) && dmem_we &&
                ((dmem_addr == ADDR_CHAR) || (dmem_addr == ADDR_INT));
    push_item = (dmem_addr == ADDR_INT) ? {KindInt, dmem_wdata}
                                        : {KindChar, 24'd0, dmem_wdata[7:0]};
    out_valid = !fifo_empty;
    pop       = out_valid && out_ready;
    // Zero the head while empty so stale storage never shows on the outputs.
    {out_kind, out_data} = fifo_empty ? '0 : head_item;
    counting  = (state_q != StHalted);
    halt      = (state_q == StHalted);
    overflow  = overflow_q;
    cycle_cnt = cycle_q;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:    if (dmem_we && (dmem_addr == ADDR_HALT)) state_d = StDrain;
      StDrain:  if (fifo_empty) state_d = StHalted;
      StHalted: state_d = StHalted;
      default:  state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      state_q    <= StRun;
      overflow_q <= 1'b0;
      cycle_q    <= '0;
    end else begin
      state_q <= state_d;
      if (push_req && fifo_full && !pop) overflow_q <= 1'b1;
      if (counting) cycle_q <= cycle_q + 32'd1;
    end
  end

  mmio_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (ItemW)
  ) u_fifo (
    .clk     (clk),
    .reset_x (reset_x),
    .push    (push_req),
    .wdata   (push_item),
    .pop     (pop),
    .rdata   (head_item),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

`ifdef MMIO_PRSTAT_EN
  logic [31:0] prnum_q, prsu_q, prmi_q, prcom_q;

  always_ff @(posedge clk or negedge reset_x) begin
    if (!reset_x) begin
      prnum_q <= '0;
      prsu_q  <= '0;
      prmi_q  <= '0;
      prcom_q <= '0;
    end else if (counting) begin
      prnum_q <= prnum_q + {31'd0, prmiss} + {31'd0, prsuccess};
      prsu_q  <= prsu_q + {31'd0, prsuccess};
      prmi_q  <= prmi_q + {31'd0, prmiss};
      prcom_q <= prcom_q + {31'd0, combranch};
    end
  end

  assign prnum_cnt = prnum_q;
  assign prsu_cnt  = prsu_q;
  assign prmi_cnt  = prmi_q;
  assign prcom_cnt = prcom_q;
`else
  logic unused_pr;
  assign unused_pr = ^{prmiss, prsuccess, combranch};
  assign prnum_cnt = '0;
  assign prsu_cnt  = '0;
  assign prmi_cnt  = '0;
  assign prcom_cnt = '0;
`endif

endmodule
